// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture: oversampling receiver for the LED matrix shift interface
// that rebuilds the displayed image into a 16x16 framebuffer with frame and error counters.
module matrix_scan_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNTWIDTH    = 8
) (
    input  logic                clk32mhz,
    input  logic                reset,
    input  logic                rclk,
    input  logic                rsdi,
    input  logic                oeb,
    input  logic                csdi,
    input  logic                cclk,
    input  logic                le,
    input  logic [3:0]          rd_row,
    output logic [15:0]         rd_data,
    output logic [3:0]          active_row,
    output logic                row_valid,
    output logic                display_on,
    output logic                frame_pulse,
    output logic [CNTWIDTH-1:0] frame_count,
    output logic [CNTWIDTH-1:0] err_count
);
    // Bit order of the sampled bundle: {rclk, rsdi, oeb, csdi, cclk, le}; oeb idles high.
    localparam logic [5:0] IDLE = 6'b001000;
    logic [5:0]  sync [SYNC_STAGES];
    logic [5:0]  dly;
    logic [5:0]  s;
    logic [5:0]  rise;
    logic [15:0] col_sr;
    logic [15:0] row_sr;
    logic [4:0]  col_bits;
    logic        commit_pend;
    logic        pend_ok;
    logic [3:0]  pend_idx;
    logic [15:0] fb [16];

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~dly;

    always_comb begin
        row_valid  = (row_sr != 16'd0) && ((row_sr & (row_sr - 16'd1)) == 16'd0);
        active_row = 4'd0;
        for (int i = 0; i < 16; i++)
            if (row_valid && row_sr[i]) active_row = 4'(i);
    end

    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= IDLE;
            dly <= IDLE;
        end else begin
            sync[0] <= {rclk, rsdi, oeb, csdi, cclk, le};
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            dly <= s;
        end
    end

    // The row is snapshotted at le detection so a coincident rclk shift cannot
    // disturb it, while the column side is read one cycle later so a coincident
    // cclk bit is included.
    always_ff @(posedge clk32mhz) begin
        if (reset) begin
            col_sr      <= '0;
            row_sr      <= '0;
            col_bits    <= '0;
            commit_pend <= 1'b0;
            pend_ok     <= 1'b0;
            pend_idx    <= '0;
            for (int i = 0; i < 16; i++) fb[i] <= '0;
            rd_data     <= '0;
            display_on  <= 1'b0;
            frame_pulse <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            display_on  <= ~s[3];
            frame_pulse <= 1'b0;
            rd_data     <= fb[rd_row];
            if (rise[1]) col_sr <= {col_sr[14:0], s[2]};
            if (commit_pend) col_bits <= '0;
            else if (rise[1] && col_bits != 5'd31) col_bits <= col_bits + 5'd1;
            if (rise[5]) row_sr <= {row_sr[14:0], s[4]};
            commit_pend <= rise[0];
            if (rise[0]) begin
                pend_ok  <= row_valid;
                pend_idx <= active_row;
            end
            if (commit_pend) begin
                if (col_bits == 5'd16 && pend_ok) begin
                    fb[pend_idx] <= col_sr;
                    if (pend_idx == 4'd15) begin
                        frame_pulse <= 1'b1;
                        frame_count <= frame_count + 1'b1;
                    end
                end else if (err_count != '1) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_capture.sv
// tb_matrix_scan_capture: drives serial matrix traffic and checks it against
// a transaction-level model of the displayed image and counters.
module tb_matrix_scan_capture;
    logic        clk32mhz = 1'b0;
    logic        reset = 1'b1;
    logic        rclk = 1'b0, rsdi = 1'b0, oeb = 1'b1, csdi = 1'b0, cclk = 1'b0, le = 1'b0;
    logic [3:0]  rd_row = 4'd0;
    logic [15:0] rd_data;
    logic [3:0]  active_row;
    logic        row_valid, display_on, frame_pulse;
    logic [7:0]  frame_count, err_count;

    matrix_scan_capture #(.SYNC_STAGES(2), .CNTWIDTH(8)) dut (
        .clk32mhz(clk32mhz), .reset(reset), .rclk(rclk), .rsdi(rsdi), .oeb(oeb),
        .csdi(csdi), .cclk(cclk), .le(le), .rd_row(rd_row), .rd_data(rd_data),
        .active_row(active_row), .row_valid(row_valid), .display_on(display_on),
        .frame_pulse(frame_pulse), .frame_count(frame_count), .err_count(err_count)
    );

    always #5 clk32mhz = ~clk32mhz;

    int vectors = 0, miscompares = 0;
    int fp_cnt = 0;
    logic [15:0] fb_m [16];
    logic [15:0] col_m = '0, row_m = '0;
    int cb = 0, err_m = 0, frm_m = 0, exp_fp = 0;

    always @(posedge clk32mhz) if (frame_pulse) fp_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [15:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk32mhz);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) fb_m[i] = '0;
        col_m = '0; row_m = '0; cb = 0; err_m = 0; frm_m = 0;
    endtask

    task automatic model_commit();
        int idx;
        idx = onehot_idx(row_m);
        if (cb == 16 && idx >= 0) begin
            fb_m[idx] = col_m;
            if (idx == 15) begin
                frm_m = (frm_m + 1) % 256;
                exp_fp++;
            end
        end else if (err_m < 255) err_m++;
        cb = 0;
    endtask

    task automatic cbit(input logic b);
        csdi = b; wait_n(1);
        cclk = 1'b1; wait_n(3);
        cclk = 1'b0; wait_n(3);
        col_m = {col_m[14:0], b};
        if (cb < 31) cb++;
    endtask

    task automatic rbit(input logic b);
        rsdi = b; wait_n(1);
        rclk = 1'b1; wait_n(3);
        rclk = 1'b0; wait_n(3);
        row_m = {row_m[14:0], b};
    endtask

    task automatic set_row(input logic [15:0] v);
        for (int i = 15; i >= 0; i--) rbit(v[i]);
    endtask

    task automatic send_col(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cbit(v[i]);
    endtask

    task automatic pulse_le();
        le = 1'b1; wait_n(3);
        le = 1'b0; wait_n(4);
        model_commit();
    endtask

    // Last column bit and the latch edge rise on the same clock.
    task automatic last_bit_with_le(input logic b);
        csdi = b; wait_n(1);
        cclk = 1'b1; le = 1'b1; wait_n(3);
        cclk = 1'b0; le = 1'b0; wait_n(4);
        col_m = {col_m[14:0], b};
        if (cb < 31) cb++;
        model_commit();
    endtask

    task automatic chk_all(input string tag);
        int idx;
        idx = onehot_idx(row_m);
        chk({tag, ".err"}, err_count, err_m);
        chk({tag, ".frames"}, frame_count, frm_m);
        chk({tag, ".valid"}, row_valid, idx >= 0);
        chk({tag, ".arow"}, active_row, idx >= 0 ? idx : 0);
        chk({tag, ".pulses"}, fp_cnt, exp_fp);
    endtask

    task automatic rd_chk(input int r);
        rd_row = 4'(r); wait_n(1);
        chk($sformatf("rd%0d", r), rd_data, fb_m[r]);
    endtask

    initial begin
        logic [15:0] v;
        int n;
        model_reset();
        wait_n(3);
        chk_all("reset");
        chk("reset.rd", rd_data, 16'h0);
        chk("reset.disp", display_on, 1'b0);
        reset = 1'b0;
        wait_n(2);

        set_row(16'h0008);
        send_col(32'hA0F1, 16);
        pulse_le();
        chk("basic.fb3", fb_m[3], 16'hA0F1);
        rd_chk(3);
        chk_all("basic");

        for (int k = 0; k < 16; k++) begin
            set_row(16'(1) << k);
            send_col($urandom, 16);
            pulse_le();
        end
        chk_all("walk");
        chk("walk.fc", frame_count, 8'd1);
        for (int r = 0; r < 16; r++) rd_chk(r);

        set_row(16'h0004);
        send_col($urandom, 15);
        pulse_le();
        chk_all("short");
        rd_chk(2);
        send_col($urandom, 16);
        pulse_le();
        chk_all("recover");
        rd_chk(2);

        set_row(16'h0009);
        send_col($urandom, 16);
        pulse_le();
        chk_all("notonehot");

        set_row(16'h0040);
        v = 16'($urandom);
        send_col({16'h0, v}, 15);
        last_bit_with_le(v[0]);
        chk_all("simul");
        rd_chk(6);

        set_row(16'h0100);
        send_col($urandom, 8);
        reset = 1'b1; wait_n(3);
        model_reset();
        chk_all("midreset");
        chk("midreset.disp", display_on, 1'b0);
        rd_chk(8);
        reset = 1'b0;
        oeb = 1'b0;
        wait_n(2);
        chk("disp.early", display_on, 1'b0);
        wait_n(1);
        chk("disp.on", display_on, 1'b1);
        set_row(16'h0020);
        send_col($urandom, 16);
        pulse_le();
        chk_all("postreset");
        rd_chk(5);

        for (int it = 0; it < 40; it++) begin
            v = ($urandom_range(0, 4) == 0) ? 16'($urandom) : (16'(1) << $urandom_range(0, 15));
            set_row(v);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 18)) : 16;
            if ($urandom_range(0, 4) == 0) begin
                send_col($urandom, n - 1);
                last_bit_with_le(1'($urandom));
            end else begin
                send_col($urandom, n);
                pulse_le();
            end
            chk_all("rand");
            rd_chk(int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/matrix_scan_capture.md
Name: matrix_scan_capture

Overview:
- Receive-side model of the 16x16 LED matrix shift-register interface (RCLK, RSDI, OEB, CSDI, CCLK, LE) driven by the pong core.
- Oversamples the six serial lines on the system clock and decodes column and row shift traffic.
- Reconstructs the displayed image into an internal 16x16 framebuffer, with a row readback port and frame and error counters.
- Used in simulation benches and as an on-chip self-check, with results routed to logic-analyzer debug bits.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per serial input (minimum 2).
- CNTWIDTH, 8: width of frame_count and err_count.

Ports:
- clk32mhz  input  1  system clock (~31.5 MHz); only clock in the block.
- reset  input  1  synchronous, active-high reset.
- rclk  input  1  row shift clock, asynchronous to clk32mhz.
- rsdi  input  1  row serial data.
- oeb  input  1  matrix output enable, active low.
- csdi  input  1  column serial data.
- cclk  input  1  column shift clock.
- le  input  1  column latch enable.
- rd_row  input  4  framebuffer row to read.
- rd_data  output  16  framebuffer contents of rd_row; bit i = column i.
- active_row  output  4  index of the currently selected row.
- row_valid  output  1  row register is exactly one-hot.
- display_on  output  1  synchronized inverse of oeb.
- frame_pulse  output  1  one-cycle pulse when row 15 is committed.
- frame_count  output  CNTWIDTH  committed frames; wraps.
- err_count  output  CNTWIDTH  protocol errors; saturates at all-ones.

Behaviour:
- Input synchronization: all six inputs pass through SYNC_STAGES flops.
  - Edge detect compares the last sync stage with one extra delay flop.
  - Total input latency is SYNC_STAGES+1 cycles.
  - Serial clocks must be high and low for at least 2 clk32mhz cycles each; faster toggling is unsupported.
- Column shift: on each detected cclk rising edge:
  - col_sr <= {col_sr[14:0], csdi_sync}. The first bit shifted ends in bit 15 after 16 edges.
  - col_bits increments, saturating at 31.
- Row shift: on each detected rclk rising edge, row_sr <= {row_sr[14:0], rsdi_sync}.
  - row_valid = (row_sr != 0) && ((row_sr & (row_sr-1)) == 0).
  - active_row = index of the set bit when row_valid, else 0.
- Commit on each detected le rising edge, one cycle after detection:
  - If col_bits == 16 and row_valid: fb[active_row] <= col_sr. If active_row == 15, pulse frame_pulse and increment frame_count.
  - Otherwise: no framebuffer write and err_count increments (saturating).
  - In all cases col_bits <= 0 and col_sr is retained.
- Simultaneous events in the same cycle:
  - cclk edge with le edge: the shift occurs first. The committed value and count include that bit.
  - rclk edge with le edge: the commit uses row_sr as it stands before the rclk shift.
- oeb has no effect on capture. It only drives display_on.
- Readback:
  - rd_data is registered, valid 1 cycle after rd_row changes.
  - Reading a row in the same cycle it is written returns the old value; the new value appears the next cycle.
- Reset values (synchronous, applied while reset is high):
  - col_sr = 0, row_sr = 0, col_bits = 0, all fb rows = 0, rd_data = 0.
  - active_row = 0, row_valid = 0, frame_pulse = 0, frame_count = 0, err_count = 0.
  - display_on = 0; sync flops hold 1 for oeb and 0 for all others.
  - Edges in progress at reset are discarded.
  - No edge is detected on the cycle reset deasserts; the delay flops are loaded from the reset value.

Test Plan:
- Shift 16 csdi bits 1010_0000_1111_0001 (first bit first) and a row pattern that leaves row_sr = 16'h0008, then pulse le -> fb[3] = 16'hA0F1; rd_row = 3 gives rd_data = 16'hA0F1 one cycle later; err_count = 0.
- Walk a one-hot row from bit 0 to bit 15, each row followed by 16 column bits and an le pulse -> 16 commits; exactly one frame_pulse on the row-15 commit; frame_count = 1.
- Send 15 column bits then le -> err_count = 1 and fb unchanged; a following clean 16-bit row commits normally.
- Set row_sr = 16'h0009 (not one-hot), send 16 column bits and le -> row_valid = 0, err_count increments, no write.
- Drive cclk and le rising in the same synchronized cycle with 16 total bits -> commit succeeds using the 16th bit.
- Assert reset mid-row after 8 column bits -> all outputs return to reset values; the next full 16-bit row commits without error; oeb held low gives display_on = 1 after SYNC_STAGES+1 cycles.
